snes_rom_loader: RTL and testbench
==================================

# snes_rom_loader

Downstream consumer of the IO subsystem's ROM byte stream (`rom_loading`, `rom_do`, `rom_do_valid`). It captures the 64-byte header block that firmware sends first and decodes the cartridge parameters from it. It packs the ROM bytes that follow into little-endian 16-bit words and writes them to SDRAM from address 0 over a req/ack port. A small byte FIFO absorbs the source's 4-byte bursts, because the source has no backpressure.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: byte FIFO depth, power of two, ≥4.
- `HDR_BYTES`, 64: number of leading stream bytes routed to the header store.
- `ADDR_W`, 23: SDRAM byte-address width (8 MB).

Ports:
- `clk`  in  1  loader clock (SNES mclk domain, same as the byte source).
- `resetn`  in  1  asynchronous, active-low reset.
- `rom_loading`  in  1  rising edge starts a load; falling edge ends it.
- `rom_do`  in  8  stream byte.
- `rom_do_valid`  in  1  single-cycle strobe per byte; may be high up to 4 consecutive cycles.
- `mem_req`  out  1  write request, level; held until acknowledged.
- `mem_ack`  in  1  one-cycle pulse completing the request.
- `mem_addr`  out  ADDR_W  even byte address of the word.
- `mem_din`  out  16  `{byte1, byte0}`, where byte0 is the earlier byte.
- `loader_busy`  out  1  high in every state other than IDLE.
- `load_done`  out  1  one-cycle pulse when a load fully retires.
- `overflow`  out  1  sticky error flag; cleared at load start.
- `byte_count`  out  ADDR_W  ROM bytes accepted for SDRAM; excludes header bytes.
- `map_mode`  out  8  header byte 0x15.
- `rom_type`  out  8  header byte 0x16.
- `rom_mask`  out  ADDR_W  decoded ROM address mask.
- `ram_mask`  out  17  decoded SRAM address mask.

## Operation
- States:
  - IDLE → HEADER on a rising edge of `rom_loading`.
  - HEADER → DATA after `HDR_BYTES` bytes.
  - DATA → FLUSH on a falling edge of `rom_loading`.
  - FLUSH → IDLE once the FIFO is empty, no word is pending or partial, and `mem_req` is low.
- Load start clears `byte_count`, all header bytes (to 0x00), `overflow`, the FIFO and the pair assembler.
- HEADER: each valid byte is written to `hdr[idx]`; `idx` counts 0..63. Header bytes never reach SDRAM.
- DATA: each valid byte is pushed into the FIFO. The assembler pops bytes alternately into the low and high halves of the word. A complete word is issued at `mem_addr = 2*word_index`.
- FLUSH with a pending odd byte: issue that word with `mem_din[15:8] = 8'h00`.
- Falling edge of `rom_loading` during HEADER: go directly to IDLE and pulse `load_done`. The partial header is still decoded.
- Rising edge of `rom_loading` in DATA or FLUSH (abort/restart):
  - The FIFO and assembler are flushed immediately.
  - An in-flight `mem_req` is held until `mem_ack`, then dropped.
  - Then enter HEADER.
  - No `load_done` pulse is issued for the aborted load.
- FIFO full and a valid byte arrives: the byte is dropped and `overflow` is set.
- `byte_count` reaches 2^ADDR_W: further bytes are dropped and `overflow` is set. The address never wraps.
- `rom_mask` decode, from `r = hdr[0x17]`:
  - r in 8..13: `(1 << (r+10)) - 1`.
  - Otherwise: all ones.
- `ram_mask` decode, from `s = hdr[0x18]`:
  - s = 0: 0.
  - s in 1..7: `(1 << (s+10)) - 1`.
  - Otherwise: 17'h1FFFF.
- Header outputs are registered and update the cycle after each header byte write.

## Timing
- Reset values:
  - All outputs 0, except `rom_mask` = all ones and `ram_mask` = 17'h1FFFF.
  - State IDLE; FIFO empty.
- `rom_loading` edges are detected against a registered copy; the action takes effect on the next edge.
- Bytes are sampled on the `clk` edge where `rom_do_valid` = 1. A strobe in the same cycle as the start edge is ignored.
- `mem_req` timing:
  - Rises ≤3 cycles after the second byte of a pair is sampled, when the FIFO was empty and no request was outstanding.
  - `mem_addr` and `mem_din` are stable from rise until the `mem_ack` cycle.
  - Falls on the cycle after `mem_ack`.
  - The next request may rise no earlier than the cycle after `mem_req` falls.
- With `mem_ack` returned 1 cycle after request, sustained throughput is ≥1 word per 4 cycles. A 4-byte burst every 8 cycles therefore never overflows at `FIFO_DEPTH`=8.
- `load_done` pulses the cycle after the FLUSH exit condition holds. `loader_busy` falls in that same cycle.
- `mem_ack` without `mem_req` is ignored.

## Test plan
- Basic load:
  - Stimulus: start; 64 header bytes with hdr[0x15]=0x21, hdr[0x17]=0x0A, hdr[0x18]=0x03; then bytes 0x00..0x07 in two 4-byte bursts; ack latency 2; end load.
  - Response: writes (0,0x0100), (2,0x0302), (4,0x0504), (6,0x0706); `map_mode`=0x21; `rom_mask`=0xFFFFF; `ram_mask`=0x1FFF; `byte_count`=8; single `load_done`.
- Odd byte count:
  - Stimulus: 5 data bytes 0xA0..0xA4.
  - Response: third write is (4,0x00A4); `byte_count`=5.
- Backpressure:
  - Stimulus: hold `mem_ack` low for 40 cycles while bursting 16 bytes.
  - Response: first 2 words are assembled, FIFO fills, later bytes are dropped, `overflow`=1, and no write is ever duplicated or reordered.
- Abort:
  - Stimulus: raise `rom_loading` again while a request is awaiting ack.
  - Response: `mem_req` holds until ack; no further old-load writes; header cleared; no `load_done` for the aborted load.
- Reset mid-DATA:
  - Stimulus: assert `resetn`=0 asynchronously.
  - Response: all outputs immediately reach their reset values; the next load behaves as in the basic-load test.
- Short header:
  - Stimulus: end load after 20 header bytes.
  - Response: IDLE, `load_done` pulse, zero SDRAM writes, `rom_mask` all ones.

Source files
------------

// File: rtl/snes_rom_loader.sv
// ROM stream loader: captures the leading header block, decodes cartridge
// parameters, and packs the remaining bytes into 16-bit SDRAM writes.
module snes_rom_loader #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned HDR_BYTES  = 64,
  parameter int unsigned ADDR_W     = 23
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rom_loading,
  input  logic [7:0]        rom_do,
  input  logic              rom_do_valid,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              loader_busy,
  output logic              load_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] byte_count,
  output logic [7:0]        map_mode,
  output logic [7:0]        rom_type,
  output logic [ADDR_W-1:0] rom_mask,
  output logic [16:0]       ram_mask
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned IdxW = $clog2(HDR_BYTES) + 1;
  localparam logic [PtrW:0]   FifoFull = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [IdxW-1:0] HdrLast  = IdxW'(HDR_BYTES - 1);
  localparam logic [IdxW-1:0] IdxMap   = IdxW'(8'h15);
  localparam logic [IdxW-1:0] IdxType  = IdxW'(8'h16);
  localparam logic [IdxW-1:0] IdxRom   = IdxW'(8'h17);
  localparam logic [IdxW-1:0] IdxRam   = IdxW'(8'h18);

  typedef enum logic [2:0] {StIdle, StHeader, StData, StFlush, StAbort} state_e;

  state_e              state_q, state_d;
  logic                loading_q;
  logic                load_rise, load_fall;
  logic                start_clr, hdr_we, push_try, load_done_d;
  logic                push, drop, pop, flush_odd, issue, flush_done;
  logic [7:0]          fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]       fifo_cnt_q;
  logic [IdxW-1:0]     hdr_idx_q;
  logic [ADDR_W:0]     cnt_q;
  logic [7:0]          lo_q;
  logic                have_lo_q, word_vld_q;
  logic [15:0]         word_q;
  logic [ADDR_W-2:0]   word_idx_q;
  logic                mem_req_q, load_done_q, overflow_q;
  logic [ADDR_W-1:0]   mem_addr_q, rom_mask_q;
  logic [15:0]         mem_din_q;
  logic [7:0]          map_mode_q, rom_type_q;
  logic [16:0]         ram_mask_q;

  function automatic logic [ADDR_W-1:0] rom_dec(input logic [7:0] r);
    logic [ADDR_W:0] one_hot;
    if (r >= 8'd8 && r <= 8'd13) begin
      one_hot = {{ADDR_W{1'b0}}, 1'b1} << (r + 8'd10);
      rom_dec = ADDR_W'(one_hot - {{ADDR_W{1'b0}}, 1'b1});
    end else begin
      rom_dec = '1;
    end
  endfunction

  function automatic logic [16:0] ram_dec(input logic [7:0] s);
    if (s == 8'd0)      ram_dec = 17'h0;
    else if (s <= 8'd7) ram_dec = 17'((18'h1 << (s + 8'd10)) - 18'h1);
    else                ram_dec = 17'h1FFFF;
  endfunction

  assign load_rise  = rom_loading & ~loading_q;
  assign load_fall  = ~rom_loading & loading_q;
  // Once 2^ADDR_W bytes are in, the address space is exhausted.
  assign push       = push_try & (fifo_cnt_q != FifoFull) & ~cnt_q[ADDR_W];
  assign drop       = push_try & ~push;
  // The assembler stalls while a finished word waits for the request port.
  assign pop        = (fifo_cnt_q != '0) & ~word_vld_q & ~start_clr;
  assign flush_odd  = (state_q == StFlush) & (fifo_cnt_q == '0) & have_lo_q & ~word_vld_q
                      & ~start_clr;
  assign issue      = word_vld_q & ~mem_req_q & ~start_clr;
  assign flush_done = (state_q == StFlush) & (fifo_cnt_q == '0) & ~have_lo_q & ~word_vld_q
                      & ~mem_req_q;

  // State register and registered copy of rom_loading for edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      loading_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      loading_q <= rom_loading;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_d     = state_q;
    start_clr   = 1'b0;
    hdr_we      = 1'b0;
    push_try    = 1'b0;
    load_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_rise) begin
          start_clr = 1'b1;
          state_d   = StHeader;
        end
      end
      StHeader: begin
        if (load_rise) begin
          start_clr = 1'b1;
        end else begin
          hdr_we = rom_do_valid;
          if (load_fall) begin
            state_d     = StIdle;
            load_done_d = 1'b1;
          end else if (rom_do_valid && hdr_idx_q == HdrLast) begin
            state_d = StData;
          end
        end
      end
      StData, StFlush: begin
        if (load_rise) begin
          // Restart: drop buffered data, but let an in-flight write finish.
          start_clr = 1'b1;
          state_d   = mem_req_q ? StAbort : StHeader;
        end else if (state_q == StData) begin
          push_try = rom_do_valid;
          if (load_fall) state_d = StFlush;
        end else if (flush_done) begin
          state_d     = StIdle;
          load_done_d = 1'b1;
        end
      end
      StAbort: begin
        if (!mem_req_q || mem_ack) state_d = rom_loading ? StHeader : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (start_clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + (PtrW + 1)'(1);
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - (PtrW + 1)'(1);
    end
  end

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rom_do;
  end

  // Header capture and parameter decode.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hdr_idx_q  <= '0;
      map_mode_q <= 8'h00;
      rom_type_q <= 8'h00;
      rom_mask_q <= '1;
      ram_mask_q <= 17'h1FFFF;
    end else if (start_clr) begin
      hdr_idx_q  <= '0;
      map_mode_q <= 8'h00;
      rom_type_q <= 8'h00;
      rom_mask_q <= rom_dec(8'h00);
      ram_mask_q <= ram_dec(8'h00);
    end else if (hdr_we) begin
      hdr_idx_q <= hdr_idx_q + IdxW'(1);
      if (hdr_idx_q == IdxMap)  map_mode_q <= rom_do;
      if (hdr_idx_q == IdxType) rom_type_q <= rom_do;
      if (hdr_idx_q == IdxRom)  rom_mask_q <= rom_dec(rom_do);
      if (hdr_idx_q == IdxRam)  ram_mask_q <= ram_dec(rom_do);
    end
  end

  // Accepted-byte count and sticky overflow.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else if (start_clr) begin
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) cnt_q <= cnt_q + (ADDR_W + 1)'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Pair assembler: low byte first, then high byte completes the word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lo_q       <= 8'h00;
      have_lo_q  <= 1'b0;
      word_q     <= 16'h0000;
      word_vld_q <= 1'b0;
      word_idx_q <= '0;
    end else if (start_clr) begin
      have_lo_q  <= 1'b0;
      word_vld_q <= 1'b0;
      word_idx_q <= '0;
    end else begin
      if (pop) begin
        if (!have_lo_q) begin
          lo_q      <= fifo_mem[rd_ptr_q];
          have_lo_q <= 1'b1;
        end else begin
          word_q     <= {fifo_mem[rd_ptr_q], lo_q};
          word_vld_q <= 1'b1;
          have_lo_q  <= 1'b0;
        end
      end else if (flush_odd) begin
        word_q     <= {8'h00, lo_q};
        word_vld_q <= 1'b1;
        have_lo_q  <= 1'b0;
      end
      if (issue) begin
        word_vld_q <= 1'b0;
        word_idx_q <= word_idx_q + (ADDR_W - 1)'(1);
      end
    end
  end

  // SDRAM request port; address and data hold until the ack cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= 16'h0000;
    end else if (issue) begin
      mem_req_q  <= 1'b1;
      mem_addr_q <= {word_idx_q, 1'b0};
      mem_din_q  <= word_q;
    end else if (mem_req_q && mem_ack) begin
      mem_req_q <= 1'b0;
    end
  end

  // Completion pulse, one cycle after the retire condition.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) load_done_q <= 1'b0;
    else         load_done_q <= load_done_d;
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign loader_busy = (state_q != StIdle);
  assign load_done   = load_done_q;
  assign overflow    = overflow_q;
  assign byte_count  = cnt_q[ADDR_W] ? '1 : cnt_q[ADDR_W-1:0];
  assign map_mode    = map_mode_q;
  assign rom_type    = rom_type_q;
  assign rom_mask    = rom_mask_q;
  assign ram_mask    = ram_mask_q;

endmodule

// File: tb/tb_snes_rom_loader.sv
// Scoreboard bench for snes_rom_loader: expected writes are queued at stimulus
// time and a negedge monitor retires them as the DUT completes requests.
module tb_snes_rom_loader;
  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          rom_loading = 1'b0;
  logic [7:0]    rom_do = 8'h00;
  logic          rom_do_valid = 1'b0;
  logic          mem_ack = 1'b0;
  logic          mem_req, loader_busy, load_done, overflow;
  logic [AW-1:0] mem_addr, byte_count, rom_mask;
  logic [15:0]   mem_din;
  logic [7:0]    map_mode, rom_type;
  logic [16:0]   ram_mask;

  snes_rom_loader #(.FIFO_DEPTH(8), .HDR_BYTES(64), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_din(mem_din), .loader_busy(loader_busy), .load_done(load_done), .overflow(overflow),
    .byte_count(byte_count), .map_mode(map_mode), .rom_type(rom_type), .rom_mask(rom_mask),
    .ram_mask(ram_mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [AW-1:0] addr; logic [15:0] din;} wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         checks = 0, failures = 0, done_cnt = 0, wr_cnt = 0;
  int         ack_lat = 1, ack_wait = 0;
  bit         ack_hold = 1'b0;
  logic [7:0] hdr_b   [64];
  logic [7:0] mdl_hdr [64];
  logic [7:0] data_q  [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference decode of the header size fields.
  function automatic logic [AW-1:0] exp_rom_mask(input int r);
    if (r >= 8 && r <= 13) return AW'((64'd1 << (r + 10)) - 64'd1);
    return {AW{1'b1}};
  endfunction

  function automatic logic [16:0] exp_ram_mask(input int s);
    if (s == 0) return 17'h0;
    if (s <= 7) return 17'((64'd1 << (s + 10)) - 64'd1);
    return 17'h1FFFF;
  endfunction

  // Ack responder: answers each request ack_lat cycles after it is seen.
  always @(posedge clk) begin
    #1;
    if (!resetn || !mem_req) begin
      mem_ack  = 1'b0;
      ack_wait = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (!ack_hold) begin
      if (ack_wait >= ack_lat) begin
        mem_ack  = 1'b1;
        ack_wait = 0;
      end else begin
        ack_wait++;
      end
    end
  end

  // Monitor: request stability, write retirement, completion pulses.
  logic [AW-1:0] held_addr;
  logic [15:0]   held_din;
  bit            req_seen = 1'b0;
  always @(negedge clk) begin
    if (!resetn) begin
      req_seen = 1'b0;
    end else begin
      if (load_done) done_cnt++;
      if (mem_req) begin
        if (!req_seen) begin
          held_addr = mem_addr;
          held_din  = mem_din;
          req_seen  = 1'b1;
        end else if (mem_addr !== held_addr || mem_din !== held_din) begin
          checks++;
          failures++;
          $display("FAIL req_stable actual=%0h/%0h required=%0h/%0h", mem_addr, mem_din,
                   held_addr, held_din);
        end
        if (mem_ack) begin
          req_seen = 1'b0;
          wr_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=%0h/%0h required=none", mem_addr, mem_din);
          end else begin
            mon_e = exp_q.pop_front();
            chk("write", 64'({mem_addr, mem_din}), 64'(mon_e));
          end
        end
      end else begin
        req_seen = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a load; the strobe in the start cycle must be ignored.
  task automatic start_load();
    for (int i = 0; i < 64; i++) mdl_hdr[i] = 8'h00;
    rom_loading  = 1'b1;
    rom_do_valid = 1'b1;
    rom_do       = 8'($urandom);
    tick();
    rom_do_valid = 1'b0;
  endtask

  task automatic send_header(input int n);
    for (int i = 0; i < n; i++) begin
      rom_do       = hdr_b[i];
      rom_do_valid = 1'b1;
      mdl_hdr[i]   = hdr_b[i];
      tick();
      if (i % 4 == 3) begin
        rom_do_valid = 1'b0;
        tick();
      end
    end
    rom_do_valid = 1'b0;
  endtask

  task automatic send_data(input int gap);
    for (int i = 0; i < data_q.size(); i++) begin
      rom_do       = data_q[i];
      rom_do_valid = 1'b1;
      tick();
      if (i % 4 == 3) begin
        rom_do_valid = 1'b0;
        repeat (gap - 4) tick();
      end
    end
    rom_do_valid = 1'b0;
  endtask

  // Words expected from the first n data bytes, little-endian, odd tail zero-padded.
  task automatic push_expect(input int n);
    wr_t  e;
    logic [7:0] hi;
    for (int i = 0; i < n; i += 2) begin
      hi     = (i + 1 < n) ? data_q[i + 1] : 8'h00;
      e.addr = AW'(i);
      e.din  = {hi, data_q[i]};
      exp_q.push_back(e);
    end
  endtask

  task automatic random_header();
    for (int i = 0; i < 64; i++) hdr_b[i] = 8'($urandom);
  endtask

  task automatic random_data(input int n);
    data_q.delete();
    for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
  endtask

  task automatic finish_load(input int exp_bytes, input bit exp_ovf, input int done0);
    rom_loading = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == done0; i++) tick();
    repeat (3) tick();
    chk("load_done_once", 64'(done_cnt), 64'(done0 + 1));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("busy_low", 64'(loader_busy), 64'd0);
    chk("map_mode", 64'(map_mode), 64'(mdl_hdr[8'h15]));
    chk("rom_type", 64'(rom_type), 64'(mdl_hdr[8'h16]));
    chk("rom_mask", 64'(rom_mask), 64'(exp_rom_mask(int'(mdl_hdr[8'h17]))));
    chk("ram_mask", 64'(ram_mask), 64'(exp_ram_mask(int'(mdl_hdr[8'h18]))));
    chk("byte_count", 64'(byte_count), 64'(exp_bytes));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
  endtask

  task automatic run_load(input int lat, input int gap);
    int done0;
    done0   = done_cnt;
    ack_lat = lat;
    start_load();
    send_header(64);
    push_expect(data_q.size());
    send_data(gap);
    finish_load(data_q.size(), 1'b0, done0);
  endtask

  task automatic basic_load();
    random_header();
    hdr_b[8'h15] = 8'h21;
    hdr_b[8'h17] = 8'h0A;
    hdr_b[8'h18] = 8'h03;
    data_q.delete();
    for (int i = 0; i < 8; i++) data_q.push_back(8'(i));
    run_load(2, 8);
    chk("basic_rom_mask", 64'(rom_mask), 64'h0FFFFF);
    chk("basic_ram_mask", 64'(ram_mask), 64'h1FFF);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done0, wr0;
    repeat (3) tick();
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(loader_busy), 64'd0);
    chk("rst_rom_mask", 64'(rom_mask), 64'h7FFFFF);
    chk("rst_ram_mask", 64'(ram_mask), 64'h1FFFF);
    resetn = 1'b1;
    tick();
    chk("rst_byte_count", 64'(byte_count), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);

    basic_load();

    // Odd byte count: final word padded with a zero high byte.
    random_header();
    data_q.delete();
    for (int i = 0; i < 5; i++) data_q.push_back(8'hA0 + 8'(i));
    run_load(1, 8);

    for (int k = 0; k < 3; k++) begin
      random_header();
      hdr_b[8'h17] = 8'($urandom_range(0, 15));
      hdr_b[8'h18] = 8'($urandom_range(0, 15));
      random_data($urandom_range(1, 40));
      run_load($urandom_range(0, 2), $urandom_range(8, 12));
    end

    // Backpressure: two words held, FIFO fills, the rest is dropped.
    done0 = done_cnt;
    random_header();
    start_load();
    send_header(64);
    ack_hold = 1'b1;
    random_data(16);
    push_expect(12);
    send_data(8);
    repeat (8) tick();
    chk("bp_overflow_during", 64'(overflow), 64'd1);
    ack_hold = 1'b0;
    finish_load(12, 1'b1, done0);

    // Abort while a request awaits ack.
    done0 = done_cnt;
    random_header();
    hdr_b[8'h15] = 8'h5A;
    start_load();
    send_header(64);
    ack_hold = 1'b1;
    random_data(4);
    push_expect(2);
    send_data(8);
    chk("abort_req_pending", 64'(mem_req), 64'd1);
    rom_loading = 1'b0;
    tick();
    rom_loading = 1'b1;
    tick();
    repeat (3) tick();
    chk("abort_req_held", 64'(mem_req), 64'd1);
    chk("abort_busy", 64'(loader_busy), 64'd1);
    chk("abort_hdr_cleared", 64'(map_mode), 64'd0);
    chk("abort_count_cleared", 64'(byte_count), 64'd0);
    ack_hold = 1'b0;
    repeat (4) tick();
    chk("abort_req_dropped", 64'(mem_req), 64'd0);
    chk("abort_no_done", 64'(done_cnt), 64'(done0));
    for (int i = 0; i < 64; i++) mdl_hdr[i] = 8'h00;
    random_header();
    send_header(64);
    random_data(10);
    push_expect(10);
    send_data(8);
    finish_load(10, 1'b0, done0);

    // Asynchronous reset mid-DATA with a request outstanding.
    random_header();
    start_load();
    send_header(64);
    ack_hold = 1'b1;
    random_data(6);
    send_data(8);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_mem_req", 64'(mem_req), 64'd0);
    chk("arst_busy", 64'(loader_busy), 64'd0);
    chk("arst_byte_count", 64'(byte_count), 64'd0);
    chk("arst_map_mode", 64'(map_mode), 64'd0);
    chk("arst_rom_mask", 64'(rom_mask), 64'h7FFFFF);
    chk("arst_ram_mask", 64'(ram_mask), 64'h1FFFF);
    exp_q.delete();
    ack_hold    = 1'b0;
    rom_loading = 1'b0;
    repeat (2) tick();
    #3;
    resetn = 1'b1;
    tick();
    basic_load();

    // Short header: load ends after 20 header bytes.
    done0 = done_cnt;
    wr0   = wr_cnt;
    random_header();
    start_load();
    send_header(20);
    finish_load(0, 1'b0, done0);
    chk("short_no_writes", 64'(wr_cnt), 64'(wr0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
